// File: rtl/audio_pwm_player.sv
// Sample-loop audio player: fetches one 16-bit sample per tick from external memory
// and plays it out as a PWM stream whose duty is updated once per PWM period.
module audio_pwm_player #(
   parameter int SAMPLE_DIV = 3200,
   parameter int READ_WAIT  = 8,
   parameter int ADDR_W     = 23,
   parameter int PWM_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [ADDR_W-1:0] end_addr,
   input  logic [15:0]       mem_data,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       sample,
   output logic              audio_pwm,
   output logic              audio_sd,
   output logic              underrun,
   output logic [1:0]        dbg_state
);

   localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int WAIT_W = (READ_WAIT > 2) ? $clog2(READ_WAIT) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      WAIT  = 2'd2,
      LATCH = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [15:0]         sample_q, sample_d;
   logic [PWM_W-1:0]    pwm_cnt_q;
   logic [PWM_W-1:0]    duty_q;
   logic [PWM_W-1:0]    duty_new;
   logic                pwm_q;
   logic                sd_q;
   logic                tick;
   logic                req;

   assign tick     = enable && (tick_cnt_q == TICK_W'(SAMPLE_DIV - 1));
   assign duty_new = {~sample_q[15], sample_q[14:16-PWM_W]};

   always_comb begin
      tick_cnt_d = tick_cnt_q + TICK_W'(1);
      if (!enable || tick) begin
         tick_cnt_d = '0;
      end
   end

   // Handshake: mem_req is a level held from REQ through WAIT; the memory is expected
   // to present valid mem_data by the LATCH cycle, READ_WAIT cycles after mem_req rose.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      addr_d     = addr_q;
      sample_d   = sample_q;
      req        = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (tick) state_d = REQ;
         end
         REQ: begin
            req        = 1'b1;
            wait_cnt_d = '0;
            state_d    = WAIT;
         end
         WAIT: begin
            req = 1'b1;
            if (wait_cnt_q == WAIT_W'(READ_WAIT - 2)) begin
               state_d = LATCH;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end
         LATCH: begin
            sample_d = mem_data;
            addr_d   = (addr_q >= end_addr) ? '0 : addr_q + ADDR_W'(1);
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Disabling abandons any fetch without touching address or sample.
      if (!enable) begin
         state_d  = IDLE;
         req      = 1'b0;
         addr_d   = addr_q;
         sample_d = sample_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         tick_cnt_q <= '0;
         wait_cnt_q <= '0;
         addr_q     <= '0;
         sample_q   <= '0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         addr_q     <= addr_d;
         sample_q   <= sample_d;
      end
   end

   // Duty only reloads at the last count so each PWM period uses a single value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_cnt_q <= '0;
         duty_q    <= {1'b1, {(PWM_W-1){1'b0}}};
         pwm_q     <= 1'b0;
         sd_q      <= 1'b0;
      end else begin
         pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
         if (pwm_cnt_q == {PWM_W{1'b1}}) begin
            duty_q <= duty_new;
         end
         pwm_q <= enable && (pwm_cnt_q < duty_q);
         sd_q  <= enable;
      end
   end

   assign mem_req   = req;
   assign mem_addr  = addr_q;
   assign sample    = sample_q;
   assign audio_pwm = pwm_q;
   assign audio_sd  = sd_q;
   assign underrun  = tick && (state_q != IDLE);
   assign dbg_state = state_q;

endmodule
